// File: rtl/register_file_param.sv
// Parameterised register file: INIT/RUN sequencer, pending-write scoreboard.
// Optional REGFILE_BYPASS_EN enables write-through forwarding on reads.
module register_file_param #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                SP_IDX  = 2,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h7fff_effc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              pend1,
  output logic              pend2,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              run;

  assign run = (state_q == S_RUN);

  // State and init index register; reset restarts the init sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, write port select and next pending vector.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en     = 1'b0;
    wr_addr   = wa;
    wr_data   = wd;
    pend_d    = pend_q;
    init_busy = 1'b0;
    unique case (state_q)
      S_INIT: begin
        init_busy       = 1'b1;
        wr_en           = 1'b1;
        wr_addr         = idx_q;
        wr_data         = (idx_q == SP_A) ? SP_INIT : '0;
        pend_d[idx_q]   = 1'b0;
        idx_d           = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (we && (wa != '0)) begin
          wr_en      = 1'b1;
          pend_d[wa] = 1'b0;
        end
        // set is applied last so it wins over a same-cycle clear
        if (sb_set && (sb_addr != '0)) begin
          pend_d[sb_addr] = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Register array write; held reset blocks all writes.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Pending vector update; held reset freezes it until init clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= pend_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (run && (a != '0)) begin
      v = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa != '0) && (a == wa)) begin
        v = wd;
      end
`endif
    end
    return v;
  endfunction

  function automatic logic pd_val(
    input logic [ADDR_W-1:0] a
  );
    logic v;
    v = 1'b0;
    if (run && (a != '0)) begin
      v = pend_q[a];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa != '0) && (a == wa)) begin
        v = sb_set && (sb_addr == a);
      end
`endif
    end
    return v;
  endfunction

  // Asynchronous read ports; zero during init and for register 0.
  always_comb begin
    rd1   = rd_val(ra1);
    rd2   = rd_val(ra2);
    pend1 = pd_val(ra1);
    pend2 = pd_val(ra2);
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: random stimulus, queue scoreboard,
// array-based reference model; also a small 8x16 instance.
module tb_register_file_param;

  localparam int DEPTH = 32;
  localparam logic [31:0] SPV = 32'h7fff_effc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        pend1;
  logic        pend2;
  logic        init_busy;

  logic [2:0]  s_ra1 = '0;
  logic [2:0]  s_ra2 = '0;
  logic        s_we = 1'b0;
  logic [2:0]  s_wa = '0;
  logic [15:0] s_wd = '0;
  logic        s_sb_set = 1'b0;
  logic [2:0]  s_sb_addr = '0;
  logic [15:0] s_rd1;
  logic [15:0] s_rd2;
  logic        s_p1;
  logic        s_p2;
  logic        s_busy;

  register_file_param dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .pend1(pend1), .pend2(pend2), .init_busy(init_busy)
  );

  register_file_param #(
    .DATA_W(16), .ADDR_W(3), .SP_IDX(7), .SP_INIT(16'h00F0)
  ) dut_s (
    .clk(clk), .rst(rst), .we(s_we), .wa(s_wa), .wd(s_wd),
    .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .sb_set(s_sb_set), .sb_addr(s_sb_addr),
    .pend1(s_p1), .pend2(s_p2), .init_busy(s_busy)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        p1;
    logic        p2;
    logic        busy;
    logic [15:0] srd1;
    logic [15:0] srd2;
    logic        sbusy;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [DEPTH];
  bit          mp [DEPTH];
  int          left = 0;
  int          s_left = 0;
  bit          started = 0;
  int          cyc = 0;

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (left > 0 || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && a == wa) return wd;
`endif
    return mem[a];
  endfunction

  function automatic logic m_pd(input logic [4:0] a);
    if (left > 0 || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && a == wa) return sb_set && sb_addr == a;
`endif
    return mp[a];
  endfunction

  function automatic logic [15:0] m_srd(input logic [2:0] a);
    if (s_left > 0) return 16'h0;
    return (a == 3'd7) ? 16'h00F0 : 16'h0;
  endfunction

  task automatic chk(input string n, input int c,
                     input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, c, act, ex);
    end
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic s, input logic [4:0] sa);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; wa = a; wd = d;
    ra1 = r1; ra2 = r2; sb_set = s; sb_addr = sa;
    s_ra1 = 3'($urandom);
    s_ra2 = 3'($urandom);
    cyc++;
    if (started) begin
      e.rd1   = m_rd(r1);
      e.rd2   = m_rd(r2);
      e.p1    = m_pd(r1);
      e.p2    = m_pd(r2);
      e.busy  = (left > 0);
      e.srd1  = m_srd(s_ra1);
      e.srd2  = m_srd(s_ra2);
      e.sbusy = (s_left > 0);
      e.cyc   = cyc;
      q.push_back(e);
    end
    if (r) begin
      left = DEPTH;
      s_left = 8;
      started = 1;
    end else begin
      if (s_left > 0) s_left--;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          foreach (mem[i]) begin
            mem[i] = (i == 2) ? SPV : 32'h0;
            mp[i] = 0;
          end
        end
      end else begin
        if (w && a != 0) begin
          mem[a] = d;
          mp[a] = 0;
        end
        if (s && sa != 0) mp[sa] = 1;
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 5'd0, 32'h0, r1, r2, 0, 5'd0);
  endtask

  task automatic rnd_step(input int rst_odds);
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  sa;
    logic        r;
    a  = 5'($urandom);
    d  = $urandom;
    r1 = ($urandom % 2 == 0) ? a : 5'($urandom);
    r2 = ($urandom % 3 == 0) ? a : 5'($urandom);
    sa = ($urandom % 2 == 0) ? a : 5'($urandom);
    r  = (rst_odds > 0) && ($urandom % rst_odds == 0);
    step(r, 1'($urandom), a, d, r1, r2, ($urandom % 4 == 0), sa);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd1", e.cyc, rd1, e.rd1);
        chk("rd2", e.cyc, rd2, e.rd2);
        chk("pend1", e.cyc, 32'(pend1), 32'(e.p1));
        chk("pend2", e.cyc, 32'(pend2), 32'(e.p2));
        chk("init_busy", e.cyc, 32'(init_busy), 32'(e.busy));
        chk("s_rd1", e.cyc, 32'(s_rd1), 32'(e.srd1));
        chk("s_rd2", e.cyc, 32'(s_rd2), 32'(e.srd2));
        chk("s_busy", e.cyc, 32'(s_busy), 32'(e.sbusy));
        chk("s_pend", e.cyc, 32'(s_p1 | s_p2), 32'h0);
      end
    end
  end

  initial begin : stim
    step(1, 0, 5'd0, 32'h0, 5'd2, 5'd5, 0, 5'd0);
    step(1, 1, 5'd4, 32'h9, 5'd2, 5'd5, 1, 5'd4);
    repeat (DEPTH) step(0, 1, 5'd6, 32'h77, 5'd2, 5'd5, 1, 5'd6);
    idle(5'd2, 5'd5);
    step(0, 1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd0, 0, 5'd0);
    step(0, 1, 5'd0, 32'h1234, 5'd7, 5'd0, 0, 5'd0);
    idle(5'd7, 5'd0);
    step(0, 0, 5'd0, 32'h0, 5'd9, 5'd9, 1, 5'd9);
    step(0, 1, 5'd9, 32'h5, 5'd9, 5'd0, 0, 5'd0);
    step(0, 1, 5'd9, 32'h6, 5'd9, 5'd9, 1, 5'd9);
    idle(5'd9, 5'd9);
    step(0, 1, 5'd3, 32'h55, 5'd3, 5'd3, 0, 5'd0);
    idle(5'd3, 5'd3);
    repeat (300) rnd_step(0);
    step(0, 1, 5'd20, 32'hAA, 5'd20, 5'd2, 0, 5'd0);
    idle(5'd20, 5'd2);
    step(1, 0, 5'd0, 32'h0, 5'd20, 5'd2, 0, 5'd0);
    repeat (10) idle(5'd20, 5'd2);
    step(1, 0, 5'd0, 32'h0, 5'd20, 5'd2, 0, 5'd0);
    repeat (DEPTH) idle(5'd20, 5'd2);
    idle(5'd20, 5'd2);
    repeat (400) rnd_step(60);
    repeat (DEPTH + 2) rnd_step(0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left in queue, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter SP_IDX, default 2, index of stack-pointer register given a non-zero init value.
REQ-004 Parameter SP_INIT, default 32'h7fff_effc, value loaded into register SP_IDX during init.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port we  input  1  write enable.
REQ-008 Port wa  input  ADDR_W  write address.
REQ-009 Port wd  input  DATA_W  write data.
REQ-010 Port ra1, ra2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-011 Port rd1, rd2  output  DATA_W  read data, ports 1 and 2, combinational.
REQ-012 Port sb_set  input  1  mark register sb_addr as pending-write (scoreboard).
REQ-013 Port sb_addr  input  ADDR_W  scoreboard set address.
REQ-014 Port pend1, pend2  output  1  pending flag of ra1 and ra2, combinational.
REQ-015 Port init_busy  output  1  high while the init sequencer runs.

Function
REQ-016 FSM states INIT and RUN; rst forces INIT with index counter idx = 0.
REQ-017 INIT: each cycle write register idx with SP_INIT if idx == SP_IDX, else 0; clear pending[idx]; idx increments.
REQ-018 INIT exits to RUN on the cycle after idx == DEPTH-1 is written; init takes exactly DEPTH cycles after rst deasserts.
REQ-019 init_busy = 1 in INIT, 0 in RUN; during INIT we and sb_set are ignored and rd1/rd2 read 0, pend1/pend2 read 0.
REQ-020 rst asserted mid-INIT restarts at idx = 0; rst held high keeps idx at 0 with no writes.
REQ-021 RUN: we = 1 and wa != 0 writes wd into register wa at rising edge; writes to address 0 are discarded.
REQ-022 Register 0 always reads 0 on both ports and never reports pending.
REQ-023 Reads are asynchronous: rdN = register[raN] for raN != 0.
REQ-024 RUN: sb_set = 1 and sb_addr != 0 sets pending[sb_addr]; a committed write to wa clears pending[wa].
REQ-025 Simultaneous sb_set and write to the same non-zero address in one cycle: set wins (pending stays 1).
REQ-026 pendN = pending[raN]; writes into the pending vector take effect on the next cycle.
REQ-027 Both read ports may address the same register in one cycle with identical results.

Reset
REQ-028 rst is sampled only on rising clk; no asynchronous path.
REQ-029 Cycle after rst high: state INIT, idx 0, init_busy 1, rd1 = rd2 = 0, pend1 = pend2 = 0.
REQ-030 All registers and the pending vector are defined only through the INIT sequence; no initial blocks are relied on.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN: when defined, in RUN with we = 1, wa != 0, raN == wa, rdN returns wd combinationally (write-through forwarding) and pendN returns 0 unless sb_set targets that address in the same cycle.
REQ-032 Without REGFILE_BYPASS_EN, rdN returns the stored value (old data) until the edge commits the write; pendN reflects stored state only.

Verification
REQ-033 rst 1 cycle, run DEPTH = 32 cycles -> init_busy high 32 cycles then low; ra1 = 2 reads 32'h7fff_effc, ra2 = 5 reads 0.
REQ-034 RUN: we = 1, wa = 7, wd = 32'hDEAD_BEEF; next cycle ra1 = 7 -> rd1 = 32'hDEAD_BEEF; we = 1, wa = 0, wd = 32'h1234 -> ra2 = 0 reads 0.
REQ-035 sb_set addr 9 -> pend1 = 1 at ra1 = 9 next cycle; write wa = 9 wd = 5 -> pend1 = 0 and rd1 = 5 next cycle; same-cycle set and write to 9 -> pend1 = 1.
REQ-036 Reassert rst at idx = 10 after register 20 holds 32'hAA -> idx restarts at 0, 32 more busy cycles, register 20 reads 0, register 2 reads SP_INIT.
REQ-037 Same cycle we = 1, wa = 3, wd = 32'h55, ra1 = 3 -> rd1 = 32'h55 with REGFILE_BYPASS_EN, old value 0 without.
REQ-038 ADDR_W = 3, DATA_W = 16, SP_IDX = 7, SP_INIT = 16'h00F0 -> init lasts 8 cycles, register 7 reads 16'h00F0, others 0.
